tape_rec: RTL and testbench
===========================

TAPE_REC -- requirements
Module: tape_rec

Interface
REQ-001 Parameter THRESH, default 16'd1400; a period shorter than THRESH ce ticks decodes as bit 1, otherwise bit 0.
REQ-002 Parameter MIN_PER, default 16'd100; a period shorter than MIN_PER ce ticks is noise.
REQ-003 Parameter TIMEOUT, default 16'd20000; this many ce ticks without a rising edge ends the recording.
REQ-004 clk  in  1  system clock (clk_sys); all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ce  in  1  single-clk timing strobe; all period counting advances only when ce=1.
REQ-007 arm  in  1  level; 1 enables capture, 0 aborts or idles.
REQ-008 cass_in  in  1  cassette output level from the PLA (cass_out).
REQ-009 wr_en  out  1  one-clk write strobe to the tape buffer RAM.
REQ-010 wr_addr  out  16  buffer byte address.
REQ-011 wr_data  out  8  decoded byte.
REQ-012 length  out  16  number of bytes written since arm rose.
REQ-013 busy  out  1  capture in progress (SYNC or RUN).
REQ-014 done  out  1  level; recording ended by timeout.
REQ-015 overflow  out  1  sticky; a byte was dropped because the buffer was full.
REQ-016 framing_err  out  1  sticky; a stop bit decoded as 0.

Function
REQ-017 cass_in passes through a 2-FF synchroniser; a rising edge is detected on the synchronised signal, adding 3 clk of latency.
REQ-018 Period counter: 16-bit, increments on ce, saturates at 16'hFFFF, and clears on each accepted rising edge.
REQ-019 FSM states: IDLE, SYNC, RUN, DONE.
REQ-020 IDLE: on arm 0->1, clear length, overflow and framing_err, then go to SYNC.
REQ-021 SYNC: wait with no time limit for the first rising edge, clear the counter, then go to RUN.
REQ-022 RUN: for an edge with period p < MIN_PER, ignore the edge and keep counting; otherwise decode bit = (p < THRESH) and clear the counter.
REQ-023 RUN: when the counter reaches TIMEOUT, go to DONE; done=1 and busy=0.
REQ-024 DONE: hold all outputs until arm=0, then go to IDLE; done stays 1 in IDLE until the next arm rise.
REQ-025 arm=0 in SYNC or RUN: next clk, go to IDLE; no further writes; length is retained.
REQ-026 Bit deframer sub-states: HUNT (wait for a 0 start bit), DATA (8 bits, MSB first), STOP1, STOP2 (each expects 1).
REQ-027 After STOP2=1, pulse wr_en for exactly one clk, one clk after the decode.
REQ-028 On that wr_en, wr_addr = the pre-increment length, and length increments in the same clk.
REQ-029 A stop bit of 0 sets framing_err, writes nothing, and returns the deframer to HUNT; that 0 bit is not reused as a start bit.
REQ-030 Boundary: when length = 16'hFFFF, a completed byte is discarded (no wr_en) and overflow is set; length stays 16'hFFFF.
REQ-031 A bit 1 decoded in HUNT is discarded (leader tone).
REQ-032 An edge and a TIMEOUT event in the same clk: the edge wins; decode it and do not time out.

Reset
REQ-033 reset_n=0 asynchronously forces: FSM=IDLE, deframer=HUNT, counter=0, synchroniser=0, and wr_en, wr_addr, wr_data, length, busy, done, overflow, framing_err all 0.
REQ-034 Reset release with arm already 1 does not start capture; an arm 0->1 transition is required.

Configuration
REQ-035 With macro TAPE_REC_GLITCH_FILTER_EN defined: synchronised cass_in must hold its new level for 4 consecutive ce strobes before an edge is recognised, and edge latency grows accordingly.
REQ-036 Without TAPE_REC_GLITCH_FILTER_EN: edges are recognised directly from the 2-FF output with no filter logic.

Verification
REQ-037 Arm, 16 periods of 700 ticks, start 0 (2000 ticks), bits 0xA5 (1=700, 0=2000 ticks), stops 1,1 -> one wr_en, wr_addr=0, wr_data=8'hA5, length=1.
REQ-038 Three framed bytes 0x00, 0xFF, 0x3C, then idle 20000 ticks -> writes at addr 0..2 with those values, done=1, busy=0, length=3.
REQ-039 Byte with STOP2 period 2000 -> framing_err=1, no wr_en, next good frame 0x11 written at addr 0.
REQ-040 A 50-tick pulse inside a 2000-tick period -> ignored; bit still decodes as 0.
REQ-041 Force length=16'hFFFF (preload via 65535 frames or backdoor), send one frame -> no wr_en, overflow=1.
REQ-042 reset_n low mid-DATA -> all outputs 0 within the same clk; arm held at 1 -> capture stays IDLE.

Source files
------------

// File: rtl/tape_rec.sv
// rtl/tape_rec.sv - cassette tape recorder capture: period decode, deframe, write to buffer RAM
// Optional macro TAPE_REC_GLITCH_FILTER_EN adds a 4-ce-strobe level filter on cass_in.
module tape_rec #(
    parameter logic [15:0] THRESH  = 16'd1400,
    parameter logic [15:0] MIN_PER = 16'd100,
    parameter logic [15:0] TIMEOUT = 16'd20000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        arm,
    input  logic        cass_in,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] length,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        framing_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] DF_HUNT  = 2'd0;
    localparam logic [1:0] DF_DATA  = 2'd1;
    localparam logic [1:0] DF_STOP1 = 2'd2;
    localparam logic [1:0] DF_STOP2 = 2'd3;

    logic        sync1, sync2;
    logic        edge_rise;
    logic [15:0] cnt;
    logic [1:0]  state;
    logic [1:0]  dstate;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [15:0] len_q;
    logic        arm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= cass_in;
            sync2 <= sync1;
        end
    end

`ifdef TAPE_REC_GLITCH_FILTER_EN
    // A new level must persist for 4 consecutive ce strobes before it is adopted.
    logic       filt_lvl, filt_prev;
    logic [1:0] filt_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_lvl  <= 1'b0;
            filt_prev <= 1'b0;
            filt_cnt  <= 2'd0;
        end else begin
            filt_prev <= filt_lvl;
            if (sync2 == filt_lvl) begin
                filt_cnt <= 2'd0;
            end else if (ce) begin
                if (filt_cnt == 2'd3) begin
                    filt_lvl <= sync2;
                    filt_cnt <= 2'd0;
                end else begin
                    filt_cnt <= filt_cnt + 2'd1;
                end
            end
        end
    end

    assign edge_rise = filt_lvl & ~filt_prev;
`else
    logic sync3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync3 <= 1'b0;
        else          sync3 <= sync2;
    end

    assign edge_rise = sync2 & ~sync3;
`endif

    logic arm_rise, run_edge, sync_edge, timeout, cnt_clr, bit_val;

    assign arm_rise  = arm & ~arm_q;
    assign sync_edge = (state == ST_SYNC) && arm && edge_rise;
    assign run_edge  = (state == ST_RUN) && arm && edge_rise && (cnt >= MIN_PER);
    // An accepted edge in the same clk as the timeout takes priority.
    assign timeout   = (state == ST_RUN) && arm && !run_edge && (cnt >= TIMEOUT);
    assign cnt_clr   = sync_edge || run_edge || ((state == ST_IDLE) && arm_rise);
    assign bit_val   = (cnt < THRESH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        cnt <= 16'd0;
        else if (cnt_clr)                    cnt <= 16'd0;
        else if (ce && (cnt != 16'hFFFF))    cnt <= cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // arm_q starts high so a reset release with arm already high is not a rise
            arm_q       <= 1'b1;
            state       <= ST_IDLE;
            dstate      <= DF_HUNT;
            bit_cnt     <= 3'd0;
            shreg       <= 8'd0;
            wr_en       <= 1'b0;
            wr_addr     <= 16'd0;
            wr_data     <= 8'd0;
            len_q       <= 16'd0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            arm_q <= arm;
            wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arm_rise) begin
                        len_q       <= 16'd0;
                        overflow    <= 1'b0;
                        framing_err <= 1'b0;
                        done        <= 1'b0;
                        dstate      <= DF_HUNT;
                        state       <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (!arm)           state <= ST_IDLE;
                    else if (edge_rise) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!arm) begin
                        state <= ST_IDLE;
                    end else if (run_edge) begin
                        case (dstate)
                            DF_HUNT: begin
                                if (!bit_val) begin
                                    dstate  <= DF_DATA;
                                    bit_cnt <= 3'd0;
                                end
                            end
                            DF_DATA: begin
                                shreg   <= {shreg[6:0], bit_val};
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) dstate <= DF_STOP1;
                            end
                            DF_STOP1: begin
                                if (bit_val) begin
                                    dstate <= DF_STOP2;
                                end else begin
                                    framing_err <= 1'b1;
                                    dstate      <= DF_HUNT;
                                end
                            end
                            default: begin
                                dstate <= DF_HUNT;
                                if (!bit_val) begin
                                    framing_err <= 1'b1;
                                end else if (len_q == 16'hFFFF) begin
                                    overflow <= 1'b1;
                                end else begin
                                    wr_en   <= 1'b1;
                                    wr_addr <= len_q;
                                    wr_data <= shreg;
                                    len_q   <= len_q + 16'd1;
                                end
                            end
                        endcase
                    end else if (timeout) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    if (!arm) state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state == ST_SYNC) || (state == ST_RUN);
    assign length = len_q;

endmodule

// File: tb/tb_tape_rec.sv
// tb/tb_tape_rec.sv - scoreboard bench for tape_rec with scaled timing parameters
module tb_tape_rec;

    localparam int SHORT = 35;
    localparam int LONG  = 100;

    logic        clk = 1'b0;
    logic        reset_n, ce, arm, cass_in;
    logic        wr_en, busy, done, overflow, framing_err;
    logic [15:0] wr_addr, length;
    logic [7:0]  wr_data;

    int n_chk = 0;
    int n_err = 0;
    logic [23:0] exp_q[$];

    tape_rec #(.THRESH(16'd70), .MIN_PER(16'd10), .TIMEOUT(16'd1000)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .arm(arm), .cass_in(cass_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .length(length),
        .busy(busy), .done(done), .overflow(overflow), .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    initial begin
        ce = 1'b0;
        forever @(negedge clk) ce = ~ce;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {wr_addr, wr_data}, 24'hxxxxxx);
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    chk("write_addr_data", {wr_addr, wr_data}, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (2 * n) @(negedge clk);
    endtask

    task automatic per(input int t);
        cass_in = 1'b1;
        tick(t / 2);
        cass_in = 1'b0;
        tick(t - t / 2);
    endtask

    task automatic leader(input int n);
        repeat (n) per(SHORT);
    endtask

    task automatic frame(input logic [7:0] b);
        per(LONG);
        for (int i = 7; i >= 0; i--) per(b[i] ? SHORT : LONG);
        per(SHORT);
        per(SHORT);
    endtask

    task automatic rearm();
        arm = 1'b0;
        tick(3);
        arm = 1'b1;
        tick(2);
    endtask

    initial begin
        reset_n = 1'b0;
        arm     = 1'b0;
        cass_in = 1'b0;
        tick(3);
        chk("reset_outputs", {wr_en, wr_addr, wr_data, length, busy, done, overflow, framing_err}, 64'd0);
        reset_n = 1'b1;
        tick(2);

        // single byte after leader tone
        arm = 1'b1;
        tick(2);
        chk("busy_after_arm", busy, 1);
        leader(16);
        exp_q.push_back({16'd0, 8'hA5});
        frame(8'hA5);
        leader(2);
        chk("len_single", length, 16'd1);
        chk("ferr_single", framing_err, 0);

        // three bytes then timeout
        rearm();
        chk("len_cleared", length, 16'd0);
        chk("done_clear_armed", done, 0);
        leader(4);
        exp_q.push_back({16'd0, 8'h00});
        exp_q.push_back({16'd1, 8'hFF});
        exp_q.push_back({16'd2, 8'h3C});
        frame(8'h00);
        frame(8'hFF);
        frame(8'h3C);
        leader(1);
        chk("busy_before_timeout", busy, 1);
        tick(1100);
        chk("done_timeout", done, 1);
        chk("busy_timeout", busy, 0);
        chk("len_three", length, 16'd3);
        arm = 1'b0;
        tick(3);
        chk("done_held_idle", done, 1);
        arm = 1'b1;
        tick(2);
        chk("done_cleared_rearm", done, 0);

        // bad stop bit, then a good frame at address 0
        leader(4);
        per(LONG);
        for (int i = 0; i < 8; i++) per((i % 2 == 0) ? SHORT : LONG);
        per(SHORT);
        per(LONG);
        leader(4);
        chk("ferr_set", framing_err, 1);
        chk("len_after_ferr", length, 16'd0);
        exp_q.push_back({16'd0, 8'h11});
        frame(8'h11);
        leader(1);
        chk("len_after_good", length, 16'd1);

        // short pulse inside a long start-bit period is ignored
        rearm();
        leader(4);
        exp_q.push_back({16'd0, 8'h5A});
        cass_in = 1'b1; tick(2);
        cass_in = 1'b0; tick(2);
        cass_in = 1'b1; tick(3);
        cass_in = 1'b0; tick(LONG - 7);
        for (int i = 7; i >= 0; i--) per((8'h5A >> i) & 1 ? SHORT : LONG);
        per(SHORT);
        per(SHORT);
        leader(1);
        chk("len_glitch", length, 16'd1);
        chk("ferr_glitch", framing_err, 0);

        // full buffer: completed byte is dropped
        rearm();
        force dut.len_q = 16'hFFFF;
        @(negedge clk);
        release dut.len_q;
        leader(4);
        frame(8'h77);
        leader(1);
        chk("overflow_set", overflow, 1);
        chk("len_saturated", length, 16'hFFFF);

        // asynchronous reset mid-DATA, arm kept high afterwards
        rearm();
        chk("overflow_cleared", overflow, 0);
        leader(4);
        exp_q.push_back({16'd0, 8'hC3});
        frame(8'hC3);
        per(LONG);
        per(SHORT);
        per(LONG);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {wr_en, wr_addr, wr_data, length, busy, done, overflow, framing_err}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        leader(4);
        frame(8'h42);
        leader(1);
        chk("no_capture_busy", busy, 0);
        chk("no_capture_len", length, 16'd0);
        arm = 1'b0;
        tick(4);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
